esfa_command_sequencer: RTL and testbench

Host-side initiator for the ESFA memory engine. Accepts one high-level request at a time over a valid/ready handshake. Expands each request into the engine's per-cycle command sequence on `selector`, `queried_handle`, `new_index` and `new_value`, and samples `resultBool`/`resultValue`. Returns one response per request over a second valid/ready handshake. Instantiated beside the engine, sharing its clock.

---
 rtl/esfa_command_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_esfa_command_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/esfa_command_sequencer.sv
// Host-side initiator for the ESFA memory engine: expands one request at a time
// into the engine's per-cycle command sequence and returns one response per request.
module esfa_command_sequencer #(
  parameter logic [7:0] SEL_IDLE   = 8'd0,
  parameter logic [7:0] SEL_LOOKUP = 8'd1,
  parameter logic [7:0] SEL_CODE   = 8'd2,
  parameter logic [7:0] SEL_WRITE  = 8'd3,
  parameter logic [7:0] SEL_ALLOC  = 8'd5,
  parameter logic [7:0] SEL_RANK   = 8'd6,
  parameter logic [7:0] SEL_RANKQ  = 8'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_handle,
  input  logic [7:0] req_index,
  input  logic [7:0] req_value,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_bool,
  output logic [7:0] rsp_value,
  output logic [7:0] selector,
  output logic [7:0] queried_handle,
  output logic [7:0] new_index,
  output logic [7:0] new_value,
  input  logic       resultBool,
  input  logic [7:0] resultValue,
  output logic [7:0] txn_count
);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_ALLOC = 2'd1;
  localparam logic [1:0] OP_RANK  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [1:0] op_r;
  logic [7:0] handle_r;
  logic [7:0] index_r;
  logic [7:0] value_r;
  logic       accept_s;
  logic       rsp_hs_s;
  logic [1:0] op_next_s;
  logic [7:0] sel_next_s;
  logic       req_ready_r;
  logic       rsp_valid_r;
  logic       rsp_bool_r;
  logic [7:0] rsp_value_r;
  logic [7:0] selector_r;
  logic [7:0] txn_count_r;

  assign accept_s = req_valid && (state_r == ST_IDLE);
  assign rsp_hs_s = rsp_ready && (state_r == ST_RESP);

  assign req_ready      = req_ready_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_bool       = rsp_bool_r;
  assign rsp_value      = rsp_value_r;
  assign selector       = selector_r;
  assign queried_handle = handle_r;
  assign new_index      = index_r;
  assign new_value      = value_r;
  assign txn_count      = txn_count_r;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; engine failures in S1/S2 short-circuit to the response
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (req_op == 2'd3) begin
            state_next_s = ST_RESP;
          end else begin
            state_next_s = ST_S1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_S1: begin
        if ((op_r == OP_ALLOC || op_r == OP_RANK) && resultBool) begin
          state_next_s = ST_S2;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      ST_S2: begin
        if (op_r == OP_RANK && resultBool) begin
          state_next_s = ST_S3;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      ST_S3:   state_next_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode for the upcoming state, so the command registers line up with it
  always_comb begin
    sel_next_s = SEL_IDLE;
    if (accept_s) begin
      op_next_s = req_op;
    end else begin
      op_next_s = op_r;
    end
    case (state_next_s)
      ST_S1: begin
        case (op_next_s)
          OP_READ:  sel_next_s = SEL_LOOKUP;
          OP_ALLOC: sel_next_s = SEL_ALLOC;
          OP_RANK:  sel_next_s = SEL_CODE;
          default:  sel_next_s = SEL_IDLE;
        endcase
      end
      ST_S2: begin
        case (op_next_s)
          OP_ALLOC: sel_next_s = SEL_WRITE;
          OP_RANK:  sel_next_s = SEL_RANK;
          default:  sel_next_s = SEL_IDLE;
        endcase
      end
      ST_S3:   sel_next_s = SEL_RANKQ;
      default: sel_next_s = SEL_IDLE;
    endcase
  end

  // Registered handshake and command outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      selector_r  <= SEL_IDLE;
    end else begin
      req_ready_r <= (state_next_s == ST_IDLE);
      rsp_valid_r <= (state_next_s == ST_RESP);
      selector_r  <= sel_next_s;
    end
  end

  // Request capture and result sampling; response starts as 0/0 on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r        <= 2'd0;
      handle_r    <= 8'd0;
      index_r     <= 8'd0;
      value_r     <= 8'd0;
      rsp_bool_r  <= 1'b0;
      rsp_value_r <= 8'd0;
    end else if (accept_s) begin
      op_r        <= req_op;
      handle_r    <= req_handle;
      index_r     <= req_index;
      value_r     <= req_value;
      rsp_bool_r  <= 1'b0;
      rsp_value_r <= 8'd0;
    end else begin
      case (state_r)
        ST_S1: begin
          if (op_r == OP_READ || (op_r == OP_ALLOC && resultBool)) begin
            rsp_bool_r  <= resultBool;
            rsp_value_r <= resultValue;
          end else begin
            rsp_bool_r  <= rsp_bool_r;
            rsp_value_r <= rsp_value_r;
          end
        end
        ST_S3: begin
          rsp_bool_r  <= resultBool;
          rsp_value_r <= resultValue;
        end
        default: begin
          rsp_bool_r  <= rsp_bool_r;
          rsp_value_r <= rsp_value_r;
        end
      endcase
    end
  end

  // Completed response handshakes, wrapping at 8 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txn_count_r <= 8'd0;
    end else if (rsp_hs_s) begin
      txn_count_r <= txn_count_r + 8'd1;
    end else begin
      txn_count_r <= txn_count_r;
    end
  end

endmodule

// File: tb/tb_esfa_command_sequencer.sv
// Directed bench for esfa_command_sequencer: a small engine model answers per selector,
// expected responses are queued by the stimulus and checked by an independent monitor.
module tb_esfa_command_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_handle, req_index, req_value;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_bool;
  logic [7:0] rsp_value;
  logic [7:0] selector, queried_handle, new_index, new_value;
  logic       resultBool;
  logic [7:0] resultValue;
  logic [7:0] txn_count;

  typedef struct packed {
    logic       b;
    logic [7:0] v;
  } rsp_t;

  rsp_t       exp_q[$];
  int         chk_cnt = 0;
  int         pass_cnt = 0;
  logic [7:0] exp_txn = 8'd0;
  int         done_txn = 0;
  logic       eng_bool [8];
  logic [7:0] eng_val  [8];

  esfa_command_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_handle(req_handle), .req_index(req_index), .req_value(req_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bool(rsp_bool), .rsp_value(rsp_value),
    .selector(selector), .queried_handle(queried_handle), .new_index(new_index), .new_value(new_value),
    .resultBool(resultBool), .resultValue(resultValue), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  // Engine model: result is a function of the selector driven this cycle
  always_comb begin
    resultBool  = 1'b0;
    resultValue = 8'd0;
    if (selector < 8'd8) begin
      resultBool  = eng_bool[selector[2:0]];
      resultValue = eng_val[selector[2:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Response monitor: every accepted response must match the head of the queue
  always @(negedge clk) begin : mon
    rsp_t e;
    if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL rsp_unexpected: got response %0b/0x%0h, expected none", rsp_bool, rsp_value);
      end else begin
        e = exp_q.pop_front();
        check("rsp_bool", {31'd0, rsp_bool}, {31'd0, e.b});
        check("rsp_value", {24'd0, rsp_value}, {24'd0, e.v});
      end
    end
  end

  task automatic set_eng(input int s, input logic b, input logic [7:0] v);
    eng_bool[s] = b;
    eng_val[s]  = v;
  endtask

  task automatic run_txn(input string tag, input logic [1:0] op, input logic [7:0] h,
                         input logic [7:0] idx, input logic [7:0] val, input int ncmd,
                         input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                         input logic eb, input logic [7:0] ev, input int hold);
    logic [7:0] sels [3];
    sels[0] = s0; sels[1] = s1; sels[2] = s2;
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_op     = op;
    req_handle = h;
    req_index  = idx;
    req_value  = val;
    rsp_ready  = (hold == 0);
    exp_q.push_back({eb, ev});
    @(negedge clk);
    check({tag, "_req_ready_idle"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_handle = 8'hEE;
    req_index  = 8'hEE;
    req_value  = 8'hEE;
    for (int k = 0; k < ncmd; k++) begin
      @(negedge clk);
      check({tag, "_selector"}, {24'd0, selector}, {24'd0, sels[k]});
      check({tag, "_rsp_valid_early"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_operands"}, {8'd0, queried_handle, new_index, new_value}, {8'd0, h, idx, val});
    end
    @(negedge clk);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_sel_resp"}, {24'd0, selector}, 32'd0);
    check({tag, "_req_ready_busy"}, {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_hold_data"}, {23'd0, rsp_bool, rsp_value}, {23'd0, eb, ev});
      check({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
      check({tag, "_hold_sel"}, {24'd0, selector}, 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    exp_txn = exp_txn + 8'd1;
    done_txn++;
    @(negedge clk);
    check({tag, "_back_idle"}, {30'd0, req_ready, rsp_valid}, 32'd2);
    check({tag, "_txn_count"}, {24'd0, txn_count}, {24'd0, exp_txn});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      eng_bool[i] = 1'b0;
      eng_val[i]  = 8'd0;
    end
    reset = 1'b0; req_valid = 1'b0; req_op = 2'd0;
    req_handle = 8'd0; req_index = 8'd0; req_value = 8'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready_valid", {30'd0, req_ready, rsp_valid}, 32'd2);
    check("reset_rsp", {23'd0, rsp_bool, rsp_value}, 32'd0);
    check("reset_sel_ops", {selector, queried_handle, new_index, new_value}, 32'd0);
    check("reset_txn", {24'd0, txn_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    set_eng(1, 1'b1, 8'h2A);
    run_txn("read", 2'd0, 8'd3, 8'd0, 8'd0, 1, 8'd1, 8'd0, 8'd0, 1'b1, 8'h2A, 0);
    set_eng(5, 1'b1, 8'd6); set_eng(3, 1'b1, 8'hFF);
    run_txn("alloc_ok", 2'd1, 8'd9, 8'd4, 8'h55, 2, 8'd5, 8'd3, 8'd0, 1'b1, 8'd6, 0);
    set_eng(5, 1'b0, 8'd9);
    run_txn("alloc_fail", 2'd1, 8'd9, 8'd7, 8'h66, 1, 8'd5, 8'd0, 8'd0, 1'b0, 8'd0, 0);
    set_eng(2, 1'b1, 8'h11); set_eng(6, 1'b0, 8'h22); set_eng(7, 1'b1, 8'h77);
    run_txn("rank_fail", 2'd2, 8'd8, 8'd1, 8'd2, 2, 8'd2, 8'd6, 8'd0, 1'b0, 8'd0, 0);
    set_eng(6, 1'b1, 8'h22);
    run_txn("rank_ok", 2'd2, 8'd8, 8'd1, 8'd2, 3, 8'd2, 8'd6, 8'd7, 1'b1, 8'h77, 0);
    set_eng(2, 1'b0, 8'h33);
    run_txn("code_fail", 2'd2, 8'd4, 8'd5, 8'd6, 1, 8'd2, 8'd0, 8'd0, 1'b0, 8'd0, 0);
    set_eng(1, 1'b0, 8'h13);
    run_txn("read_miss", 2'd0, 8'd200, 8'd0, 8'd0, 1, 8'd1, 8'd0, 8'd0, 1'b0, 8'h13, 0);
    run_txn("illegal_hold", 2'd3, 8'd1, 8'd2, 8'd3, 0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 5);

    while (done_txn < 256) begin
      run_txn("wrap", 2'd3, done_txn[7:0], 8'd0, 8'd0, 0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 0);
    end
    check("txn_wrap_zero", {24'd0, txn_count}, 32'd0);

    // Reset during the write command of an ALLOC_WRITE; its response must never appear
    set_eng(5, 1'b1, 8'd6);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'd1; req_index = 8'd4; req_value = 8'h55; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_sel_alloc", {24'd0, selector}, 32'd5);
    @(posedge clk); #1;
    check("rst_mid_sel_write", {24'd0, selector}, 32'd3);
    reset = 1'b0;
    #1;
    check("rst_async_sel", {24'd0, selector}, 32'd0);
    check("rst_async_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_async_txn", {24'd0, txn_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_txn = 8'd0;
    repeat (4) begin
      @(negedge clk);
      check("rst_after_idle", {30'd0, req_ready, rsp_valid}, 32'd2);
      check("rst_after_sel", {24'd0, selector}, 32'd0);
    end
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
